// File: rtl/rx_packet_writer.sv
// rx_packet_writer: frames SYNC, LEN, PAYLOAD[LEN], CSUM from a UART byte stream into the RX RAM.
// Optional inter-byte timeout is compiled in when RX_TIMEOUT_EN is defined.
module rx_packet_writer #(
  parameter int unsigned NUMBER    = 256,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
`ifdef RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 100000
`endif
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic [7:0]                wr_rx_data,
  output logic [$clog2(NUMBER)-1:0] wr_rx_addr,
  output logic                      we_rx,
  output logic                      pkt_ready,
  output logic [7:0]                pkt_len,
  input  logic                      pkt_ack,
  output logic                      pkt_error,
  output logic                      pkt_overrun,
  output logic                      busy
);

  localparam int unsigned AW = $clog2(NUMBER);
  localparam int unsigned IW = AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StCsum,
    StHold
  } state_e;

  state_e          state_q;
  logic [7:0]      len_q;
  logic [7:0]      sum_q;
  logic [IW-1:0]   idx_q;
  logic            we_q;
  logic [7:0]      wdata_q;
  logic [AW-1:0]   waddr_q;
  logic            ready_q;
  logic [7:0]      plen_q;
  logic            err_q;
  logic            ovr_q;

  logic [IW-1:0]   idx_inc;
  logic [7:0]      sum_add;
  logic            len_bad;
  logic            last_byte;
  logic            in_frame;
  logic            tmo_hit;

  always_comb begin
    idx_inc   = idx_q + IW'(1);
    sum_add   = sum_q + rx_data;
    len_bad   = (rx_data == 8'd0) || (32'(rx_data) > NUMBER);
    last_byte = (32'(idx_inc) == 32'(len_q));
    in_frame  = (state_q == StLen) || (state_q == StPayload) || (state_q == StCsum);
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_q;

  assign tmo_hit = in_frame && !rx_valid && (tmo_q == TW'(TIMEOUT - 1));

  // Counts idle cycles between bytes; IDLE and HOLD keep it parked at zero.
  always_ff @(posedge clock) begin
    if (!reset_n || !in_frame || rx_valid || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      len_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      ready_q <= 1'b0;
      plen_q  <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            sum_q   <= '0;
            idx_q   <= '0;
            state_q <= StLen;
          end
        end
        StLen: begin
          if (rx_valid) begin
            if (len_bad) begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              len_q   <= rx_data;
              sum_q   <= rx_data;
              state_q <= StPayload;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StPayload: begin
          if (rx_valid) begin
            we_q    <= 1'b1;
            wdata_q <= rx_data;
            waddr_q <= idx_q[AW-1:0];
            idx_q   <= idx_inc;
            sum_q   <= sum_add;
            if (last_byte) begin
              state_q <= StCsum;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StCsum: begin
          if (rx_valid) begin
            if (sum_add == 8'd0) begin
              ready_q <= 1'b1;
              plen_q  <= len_q;
              state_q <= StHold;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StHold: begin
          // Ack wins over a simultaneous byte, so overrun ends cleared.
          if (pkt_ack) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            state_q <= StIdle;
          end else if (rx_valid) begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_rx_data  = wdata_q;
  assign wr_rx_addr  = waddr_q;
  assign we_rx       = we_q;
  assign pkt_ready   = ready_q;
  assign pkt_len     = plen_q;
  assign pkt_error   = err_q;
  assign pkt_overrun = ovr_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_rx_packet_writer.sv
// Self-checking bench for rx_packet_writer with NUMBER=16; timeout checks when RX_TIMEOUT_EN is set.
module tb_rx_packet_writer;

  localparam int unsigned NUM = 16;
  localparam int unsigned AW  = $clog2(NUM);
`ifdef RX_TIMEOUT_EN
  localparam int unsigned TMO = 20;
`endif

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data  = 8'd0;
  logic          pkt_ack  = 1'b0;
  logic [7:0]    wr_rx_data;
  logic [AW-1:0] wr_rx_addr;
  logic          we_rx;
  logic          pkt_ready;
  logic [7:0]    pkt_len;
  logic          pkt_error;
  logic          pkt_overrun;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  rx_packet_writer #(
    .NUMBER    (NUM),
    .SYNC_BYTE (8'hA5)
`ifdef RX_TIMEOUT_EN
    ,
    .TIMEOUT   (TMO)
`endif
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .wr_rx_data  (wr_rx_data),
    .wr_rx_addr  (wr_rx_addr),
    .we_rx       (we_rx),
    .pkt_ready   (pkt_ready),
    .pkt_len     (pkt_len),
    .pkt_ack     (pkt_ack),
    .pkt_error   (pkt_error),
    .pkt_overrun (pkt_overrun),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at a negedge; outputs it causes are visible on return.
  task automatic cyc(input logic v, input logic [7:0] d, input logic a);
    rx_valid = v;
    rx_data  = d;
    pkt_ack  = a;
    @(negedge clock);
    rx_valid = 1'b0;
    pkt_ack  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input bit e_we, input int e_addr, input int e_data,
                            input bit e_err, input bit e_rdy, input bit e_busy);
    chk({tag, ".we"}, 32'(we_rx), 32'(e_we));
    if (e_we) begin
      chk({tag, ".addr"}, 32'(wr_rx_addr), 32'(e_addr));
      chk({tag, ".data"}, 32'(wr_rx_data), 32'(e_data));
    end
    chk({tag, ".err"}, 32'(pkt_error), 32'(e_err));
    chk({tag, ".rdy"}, 32'(pkt_ready), 32'(e_rdy));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".we"}, 32'(we_rx), 32'd0);
    chk({tag, ".addr"}, 32'(wr_rx_addr), 32'd0);
    chk({tag, ".data"}, 32'(wr_rx_data), 32'd0);
    chk({tag, ".rdy"}, 32'(pkt_ready), 32'd0);
    chk({tag, ".len"}, 32'(pkt_len), 32'd0);
    chk({tag, ".err"}, 32'(pkt_error), 32'd0);
    chk({tag, ".ovr"}, 32'(pkt_overrun), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  // Reference: checksum byte that makes len + payload + csum == 0 mod 256.
  function automatic logic [7:0] good_cs(input int l, input logic [7:0] q[$]);
    int s;
    s = l;
    for (int i = 0; i < l; i++) s += int'(q[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic send_frame(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] cs,
                            input bit gaps, output bit accepted);
    int sum;
    accepted = 1'b0;
    cyc(1'b1, 8'hA5, 1'b0);
    expect_out("sync", 0, 0, 0, 0, 0, 1);
    cyc(1'b1, len, 1'b0);
    if (len == 8'd0 || 32'(len) > NUM) begin
      expect_out("len_bad", 0, 0, 0, 1, 0, 0);
      return;
    end
    expect_out("len", 0, 0, 0, 0, 0, 1);
    sum = int'(len);
    for (int i = 0; i < int'(len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        cyc(1'b0, 8'd0, 1'b0);
        expect_out("gap", 0, 0, 0, 0, 0, 1);
      end
      cyc(1'b1, pl[i], 1'b0);
      expect_out("pay", 1, i, int'(pl[i]), 0, 0, 1);
      sum += int'(pl[i]);
    end
    cyc(1'b1, cs, 1'b0);
    accepted = ((sum + int'(cs)) % 256) == 0;
    if (accepted) begin
      expect_out("csum_ok", 0, 0, 0, 0, 1, 1);
      chk("pkt_len", 32'(pkt_len), 32'(len));
    end else begin
      expect_out("csum_bad", 0, 0, 0, 1, 0, 0);
    end
    chk("ovr_clear", 32'(pkt_overrun), 32'd0);
  endtask

  task automatic hold_and_ack(input logic [7:0] len, input int extra, input bit ack_byte);
    for (int k = 0; k < extra; k++) begin
      cyc(1'b1, 8'($urandom), 1'b0);
      expect_out("hold_rx", 0, 0, 0, 0, 1, 1);
      chk("hold_len", 32'(pkt_len), 32'(len));
      chk("hold_ovr", 32'(pkt_overrun), 32'd1);
    end
    if (extra == 0) chk("hold_noovr", 32'(pkt_overrun), 32'd0);
    cyc(ack_byte, 8'($urandom), 1'b1);
    expect_out("ack", 0, 0, 0, 0, 0, 0);
    chk("ack_ovr", 32'(pkt_overrun), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] cs;
    logic [7:0] nb;
    bit         acc;
    int         l;

    reset_n = 1'b0;
    cyc(1'b0, 8'd0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0);
    reset_n = 1'b1;
    check_zero("reset");

    // Directed good frame of 3 bytes.
    q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'd3, q, good_cs(3, q), 1'b0, acc);
    chk("good_acc", 32'(acc), 32'd1);
    hold_and_ack(8'd3, 0, 1'b0);

    // Bad checksum, then a good frame is still accepted.
    q = '{8'h10, 8'h20};
    send_frame(8'd2, q, 8'h00, 1'b0, acc);
    q = '{8'hA5, 8'h01};
    send_frame(8'd2, q, good_cs(2, q), 1'b0, acc);
    hold_and_ack(8'd2, 0, 1'b0);

    // Length boundaries.
    send_frame(8'h11, q, 8'h00, 1'b0, acc);
    send_frame(8'h00, q, 8'h00, 1'b0, acc);
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(8'(i * 7 + 3));
    send_frame(8'h10, q, good_cs(16, q), 1'b0, acc);

    // Overrun in HOLD, ack together with a 4th byte.
    hold_and_ack(8'h10, 3, 1'b1);

    // Ack outside HOLD and noise in IDLE are ignored.
    cyc(1'b0, 8'd0, 1'b1);
    expect_out("idle_ack", 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 8'h00, 1'b0);
    expect_out("noise00", 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 8'hFF, 1'b0);
    expect_out("noiseFF", 0, 0, 0, 0, 0, 0);
    cyc(1'b1, 8'h5A, 1'b0);
    expect_out("noise5A", 0, 0, 0, 0, 0, 0);

    // Reset mid-payload abandons the frame silently.
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 8'd5, 1'b0);
    cyc(1'b1, 8'h44, 1'b0);
    expect_out("pre_rst", 1, 0, 8'h44, 0, 0, 1);
    reset_n = 1'b0;
    cyc(1'b1, 8'h55, 1'b0);
    reset_n = 1'b1;
    check_zero("mid_rst");
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(8'd4, q, good_cs(4, q), 1'b0, acc);
    chk("post_rst_acc", 32'(acc), 32'd1);
    hold_and_ack(8'd4, 1, 1'b0);

    // Randomized frames against the reference rules.
    for (int f = 0; f < 40; f++) begin
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h5A;
        cyc(1'b1, nb, 1'b0);
        expect_out("rnd_noise", 0, 0, 0, 0, 0, 0);
      end
      l = int'($urandom_range(0, NUM + 2));
      q.delete();
      for (int i = 0; i < l; i++) q.push_back(8'($urandom));
      cs = good_cs(l, q);
      if ($urandom_range(0, 3) == 0) cs = cs + 8'($urandom_range(1, 255));
      send_frame(8'(l), q, cs, 1'b1, acc);
      if (acc) hold_and_ack(8'(l), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

`ifdef RX_TIMEOUT_EN
    begin
      int edges;
      // Stall after the first payload byte: error after exactly TMO edges.
      cyc(1'b1, 8'hA5, 1'b0);
      cyc(1'b1, 8'd4, 1'b0);
      rx_valid = 1'b1;
      rx_data  = 8'h01;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
      edges = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clock);
        #1;
        if (pkt_error) begin
          edges = k;
          break;
        end
      end
      chk("tmo_edges", 32'(edges), 32'(TMO));
      @(negedge clock);
      chk("tmo_idle", 32'(busy), 32'd0);

      // Late bytes at 19 and 20 edges after the previous one are still accepted.
      q = '{8'h01, 8'h02, 8'h03, 8'h04};
      cyc(1'b1, 8'hA5, 1'b0);
      cyc(1'b1, 8'd4, 1'b0);
      repeat (18) cyc(1'b0, 8'd0, 1'b0);
      cyc(1'b1, q[0], 1'b0);
      expect_out("tmo19", 1, 0, 1, 0, 0, 1);
      repeat (19) cyc(1'b0, 8'd0, 1'b0);
      cyc(1'b1, q[1], 1'b0);
      expect_out("tmo20", 1, 1, 2, 0, 0, 1);
      cyc(1'b1, q[2], 1'b0);
      cyc(1'b1, q[3], 1'b0);
      cyc(1'b1, good_cs(4, q), 1'b0);
      expect_out("tmo_ok", 0, 0, 0, 0, 1, 1);
      hold_and_ack(8'd4, 0, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
